mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Word-addressed 16-bit memory target for the multi-cycle CPU.
- Serves instruction fetches, loads and stores over a 4-phase req/ack handshake.
- Inserts a programmable number of wait states before each response.
- Includes an idle-only preload port so a bench or boot loader can fill program memory before the CPU runs.

Parameters:
DEPTH, 256, number of 16-bit words; legal addresses are 0..DEPTH-1
LATENCY, 2, wait cycles between request acceptance and the access; 0 is legal
INIT_ZERO, 1, 1 = memory array is zeroed at time 0 (simulation init only; reset does not clear it)

Ports:
clk  input  1  system clock, all state updates on its rising edge
reset  input  1  synchronous, active-high; sampled on the rising edge of clk
req  input  1  request from initiator; held high until ack is seen
we  input  1  1 = store, 0 = read (fetch/load); sampled at acceptance
addr  input  16  word address; sampled at acceptance
wdata  input  16  store data; sampled at acceptance
rdata  output  16  read data; valid while ack=1 for a read
ack  output  1  response; held high until req is sampled low
err  output  1  out-of-range flag for the current response; valid while ack=1
busy  output  1  high whenever state is not IDLE
pl_en  input  1  preload write strobe; honoured in IDLE only
pl_addr  input  16  preload word address
pl_data  input  16  preload data

Behaviour:
- Reset values: state=IDLE, ack=0, rdata=0x0000, err=0, busy=0, wait counter=0. Memory contents are retained.
- Reset mid-transaction aborts immediately. A store that has not yet reached its access edge is not performed.
- States:
  - IDLE: if pl_en=1, write pl_data to mem[pl_addr] when pl_addr<DEPTH; out-of-range preloads are dropped. pl_en has priority and blocks req acceptance that cycle. Otherwise, if req=1, latch we/addr/wdata, load counter=LATENCY, go WAIT.
  - WAIT: if counter!=0, decrement. If counter==0, perform the access on this edge, set ack=1, go HOLD.
    - Read in range: rdata<=mem[addr_latched], err<=0.
    - Write in range: mem[addr_latched]<=wdata_latched, rdata unchanged, err<=0.
    - Out of range (addr_latched>=DEPTH): no memory change; read returns rdata<=0x0000; err<=1.
  - HOLD: ack=1, rdata and err stable. When req is sampled 0, set ack=0, err=0, go IDLE. rdata keeps its last value.
- Latency: request sampled at edge E is accepted. ack rises at edge E+LATENCY+1. ack falls at the first edge where req=0 is sampled in HOLD.
- Back-to-back transactions: minimum of one IDLE cycle between transactions, because req must go low and the responder must return to IDLE.
- Inputs ignored outside IDLE:
  - changes to we/addr/wdata after acceptance have no effect;
  - pl_en asserted outside IDLE is ignored, with no write and no error.
- Dropping req while in WAIT (protocol violation): the transaction still completes; ack is raised, then cleared on the next edge because req=0.
- Addresses compare as full 16-bit unsigned against DEPTH; there is no wrap-around.
- busy is combinational from state: 1 in WAIT and HOLD.

Test Plan:
- Reset, then preload mem[0x0003]=0xA5C3; read 0x0003 with LATENCY=2 -> accept at edge E, ack=1 at E+3, rdata=0xA5C3, err=0; drop req -> ack=0 next edge, busy=0.
- Write 0x1234 to 0x0010, then read 0x0010 -> second response rdata=0x1234. A further read of 0x0011 (preloaded 0x0000) returns 0x0000, confirming no neighbour corruption.
- Read addr 0x0100 with DEPTH=256 -> ack with err=1, rdata=0x0000. Write to 0x0100 -> err=1, and a later read of 0x0000 is unchanged.
- LATENCY=0 build: req at edge E -> ack at E+1. Hold req high for 5 cycles -> ack stays 1 and no second transaction starts; busy=1 throughout.
- Assert reset in WAIT of a write 0xBEEF to 0x0020 -> ack=0, busy=0, rdata=0x0000 next edge; later read 0x0020 returns its prior value, not 0xBEEF.
- pl_en and req both high in IDLE -> preload written, req accepted one cycle later. pl_en pulsed during HOLD -> no memory change.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed 16-bit memory target with a 4-phase req/ack handshake,
// programmable wait states before each access, and an idle-only preload port.

module mem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned LATENCY   = 2,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    input  logic        pl_en,
    input  logic [15:0] pl_addr,
    input  logic [15:0] pl_data
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    // One spare value so LATENCY=0 still yields a legal 1-bit counter.
    localparam int unsigned CntW  = $clog2(LATENCY + 2);
    localparam logic [16:0] DepthW = 17'(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [15:0]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;

    logic              mem_we;
    logic [AddrW-1:0]  mem_waddr;
    logic [15:0]       mem_wdata;

    // Contents survive reset; the initializer only sets the power-up image.
    logic [15:0] mem_q [DEPTH] = '{default: (INIT_ZERO ? 16'h0000 : 16'hxxxx)};

    logic             acc_in_range;
    logic             pl_in_range;
    logic [15:0]      rd_word;

    assign acc_in_range = ({1'b0, addr_q} < DepthW);
    assign pl_in_range  = ({1'b0, pl_addr} < DepthW);
    assign rd_word      = mem_q[addr_q[AddrW-1:0]];

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Memory array write port; reset suppresses any pending store or preload.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Next-state, request latching and access decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        ack_d     = ack_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = addr_q[AddrW-1:0];
        mem_wdata = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (pl_en) begin
                    // Preload wins the cycle; out-of-range preloads vanish.
                    if (pl_in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = pl_addr[AddrW-1:0];
                        mem_wdata = pl_data;
                    end
                end else if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CntW'(LATENCY);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ack_d   = 1'b1;
                    state_d = StHold;
                    if (acc_in_range) begin
                        err_d = 1'b0;
                        if (we_q) begin
                            mem_we = 1'b1;
                        end else begin
                            rdata_d = rd_word;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (!we_q) begin
                            rdata_d = 16'h0000;
                        end
                    end
                end
            end
            StHold: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: registered response plus busy decoded from state.
    always_comb begin
        busy  = (state_q != StIdle);
        ack   = ack_q;
        err   = err_q;
        rdata = rdata_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance driven from a vector
// table plus hand-written sequences, and a LATENCY=0 instance for hold checks.

module tb_mem_responder;

    localparam int unsigned Lat = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, we, pl_en;
    logic [15:0] addr, wdata, pl_addr, pl_data;
    logic [15:0] rdata;
    logic        ack, err, busy;

    logic        req0, pl_en0;
    logic [15:0] addr0, pl_addr0, pl_data0;
    logic [15:0] rdata0;
    logic        ack0, err0, busy0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(256), .LATENCY(Lat), .INIT_ZERO(1'b1)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy),
        .pl_en(pl_en), .pl_addr(pl_addr), .pl_data(pl_data)
    );

    mem_responder #(.DEPTH(256), .LATENCY(0), .INIT_ZERO(1'b1)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(1'b0), .addr(addr0), .wdata(16'h0000),
        .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0),
        .pl_en(pl_en0), .pl_addr(pl_addr0), .pl_data(pl_data0)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        chk_rd;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    // Counts edges after acceptance until ack, bounded.
    task automatic wait_ack(output int n);
        n = 0;
        while (!ack && n < 16) begin
            tick();
            n++;
        end
    endtask

    // Full handshake: accept, wait, compare response, drop req, confirm release.
    task automatic xact(input vec_t v, input string name);
        int n;
        req   = 1'b1;
        we    = v.we;
        addr  = v.addr;
        wdata = v.wdata;
        tick();
        check({name, " busy@accept"}, 16'(busy), 16'd1);
        wait_ack(n);
        check({name, " latency"}, 16'(n), 16'(Lat + 1));
        check({name, " err"}, 16'(err), 16'(v.exp_err));
        if (v.chk_rd) check({name, " rdata"}, rdata, v.exp_rdata);
        req = 1'b0;
        tick();
        check({name, " ack release"}, 16'(ack), 16'd0);
        check({name, " busy release"}, 16'(busy), 16'd0);
    endtask

    vec_t vecs[9];

    initial begin
        int n;
        vecs[0] = '{we: 1'b0, addr: 16'h0003, wdata: 16'h0000, chk_rd: 1'b1, exp_rdata: 16'hA5C3, exp_err: 1'b0};
        vecs[1] = '{we: 1'b1, addr: 16'h0010, wdata: 16'h1234, chk_rd: 1'b0, exp_rdata: 16'h0000, exp_err: 1'b0};
        vecs[2] = '{we: 1'b0, addr: 16'h0010, wdata: 16'h0000, chk_rd: 1'b1, exp_rdata: 16'h1234, exp_err: 1'b0};
        vecs[3] = '{we: 1'b0, addr: 16'h0011, wdata: 16'h0000, chk_rd: 1'b1, exp_rdata: 16'h0000, exp_err: 1'b0};
        vecs[4] = '{we: 1'b0, addr: 16'h00FF, wdata: 16'h0000, chk_rd: 1'b1, exp_rdata: 16'h7777, exp_err: 1'b0};
        vecs[5] = '{we: 1'b0, addr: 16'h0100, wdata: 16'h0000, chk_rd: 1'b1, exp_rdata: 16'h0000, exp_err: 1'b1};
        vecs[6] = '{we: 1'b1, addr: 16'h0100, wdata: 16'hDEAD, chk_rd: 1'b0, exp_rdata: 16'h0000, exp_err: 1'b1};
        vecs[7] = '{we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, chk_rd: 1'b1, exp_rdata: 16'h0000, exp_err: 1'b1};
        vecs[8] = '{we: 1'b0, addr: 16'h0000, wdata: 16'h0000, chk_rd: 1'b1, exp_rdata: 16'h5A5A, exp_err: 1'b0};

        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        req0 = 1'b0; pl_en0 = 1'b0; addr0 = '0; pl_addr0 = '0; pl_data0 = '0;
        tick();
        tick();
        check("reset ack", 16'(ack), 16'd0);
        check("reset busy", 16'(busy), 16'd0);
        check("reset rdata", rdata, 16'h0000);
        check("reset err", 16'(err), 16'd0);
        reset = 1'b0;
        tick();

        preload(16'h0003, 16'hA5C3);
        preload(16'h0011, 16'h0000);
        preload(16'h00FF, 16'h7777);
        preload(16'h0000, 16'h5A5A);
        preload(16'h0020, 16'h1111);
        preload(16'h0100, 16'hBAD0);

        foreach (vecs[i]) begin
            xact(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during WAIT of a store: aborted, memory untouched.
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'hBEEF;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst-wait ack", 16'(ack), 16'd0);
        check("rst-wait busy", 16'(busy), 16'd0);
        check("rst-wait rdata", rdata, 16'h0000);
        reset = 1'b0; req = 1'b0;
        tick();
        xact('{we: 1'b0, addr: 16'h0020, wdata: 16'h0000, chk_rd: 1'b1, exp_rdata: 16'h1111, exp_err: 1'b0},
             "rst-wait reread");

        // Preload and request together: preload first, request one edge later.
        pl_en = 1'b1; pl_addr = 16'h0030; pl_data = 16'h3C3C;
        req = 1'b1; we = 1'b0; addr = 16'h0030;
        tick();
        check("pl+req busy", 16'(busy), 16'd0);
        pl_en = 1'b0;
        tick();
        check("pl+req accept", 16'(busy), 16'd1);
        wait_ack(n);
        check("pl+req latency", 16'(n), 16'(Lat + 1));
        check("pl+req rdata", rdata, 16'h3C3C);

        // Preload pulse while in HOLD must be ignored.
        pl_en = 1'b1; pl_addr = 16'h0030; pl_data = 16'hFFFF;
        tick();
        pl_en = 1'b0;
        check("pl-hold ack", 16'(ack), 16'd1);
        req = 1'b0;
        tick();
        xact('{we: 1'b0, addr: 16'h0030, wdata: 16'h0000, chk_rd: 1'b1, exp_rdata: 16'h3C3C, exp_err: 1'b0},
             "pl-hold reread");

        // req dropped in WAIT, addr changed after acceptance.
        req = 1'b1; we = 1'b0; addr = 16'h0003;
        tick();
        req = 1'b0; addr = 16'h0010;
        tick();
        tick();
        tick();
        check("drop-wait ack", 16'(ack), 16'd1);
        check("drop-wait rdata", rdata, 16'hA5C3);
        tick();
        check("drop-wait ack clear", 16'(ack), 16'd0);
        check("drop-wait busy", 16'(busy), 16'd0);

        // LATENCY=0 instance: ack one edge after acceptance, held while req high.
        pl_en0 = 1'b1; pl_addr0 = 16'h0005; pl_data0 = 16'h0BAD;
        tick();
        pl_en0 = 1'b0;
        req0 = 1'b1; addr0 = 16'h0005;
        tick();
        check("lat0 ack@accept", 16'(ack0), 16'd0);
        check("lat0 busy@accept", 16'(busy0), 16'd1);
        tick();
        check("lat0 ack", 16'(ack0), 16'd1);
        check("lat0 rdata", rdata0, 16'h0BAD);
        check("lat0 err", 16'(err0), 16'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("lat0 hold ack %0d", k), 16'(ack0), 16'd1);
            check($sformatf("lat0 hold busy %0d", k), 16'(busy0), 16'd1);
        end
        req0 = 1'b0;
        tick();
        check("lat0 ack release", 16'(ack0), 16'd0);
        check("lat0 busy release", 16'(busy0), 16'd0);
        tick();
        check("lat0 stays idle", 16'(busy0), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before timeout");
        $fatal(1, "timeout");
    end

endmodule
